fetch_exec_sequencer: RTL and testbench
=======================================

Name: fetch_exec_sequencer

Overview:
- Top-level control FSM for the CPU pipeline.
- Accepts an ap_ctrl_hs-style run request from the host, then loops fetch → execute by driving the ap_start/ap_done handshakes of the fetch unit and the execute unit.
- Tracks PC and iteration count; terminates on halt, iteration limit, abort or misaligned PC, and reports the cause.
- Replaces the free-running loop inside the HLS top with an explicit, observable sequencer.

Parameters:
PC_W, 32, program counter width (byte address, word-aligned)
INSTR_W, 32, instruction width
CNT_W, 32, iteration counter / limit width

Ports:
ap_clk  in  1  clock; all logic on rising edge
ap_rst_n  in  1  asynchronous active-low reset
ap_start  in  1  host run request, level, sampled only in IDLE
ap_done  out  1  one-cycle pulse at end of run
ap_idle  out  1  high in IDLE
ap_ready  out  1  one-cycle pulse, coincident with ap_done
start_pc  in  PC_W  initial PC, latched on accepted ap_start
max_iter  in  CNT_W  iteration limit, latched on accepted ap_start; 0 = unlimited
abort  in  1  level; requests early termination
fetch_start  out  1  start to fetch unit
fetch_pc  out  PC_W  PC presented to fetch unit
fetch_done  in  1  fetch completion pulse
fetch_instr  in  INSTR_W  fetched word, valid with fetch_done
exec_start  out  1  start to execute unit
exec_pc  out  PC_W  PC of instruction being executed
exec_instr  out  INSTR_W  latched instruction
exec_done  in  1  execute completion pulse
exec_next_pc  in  PC_W  next PC, valid with exec_done
exec_halt  in  1  halt indication, valid with exec_done
iter_count  out  CNT_W  completed iterations in current/last run
final_pc  out  PC_W  PC after last completed iteration
status  out  3  termination cause, see package

Behaviour:
- Reset (async assert, sync deassert by the environment): state=IDLE; ap_idle=1; every other output 0, including pc, instr, iter_count, final_pc and status=ST_NONE.
- States: IDLE, FETCH, EXEC, DONE.
- IDLE, ap_start=1:
  - latch start_pc → pc and max_iter → lim; clear iter_count, abort_pend and status.
  - If start_pc[1:0]!=0: go to DONE with status=ST_MISALIGN and iter_count=0.
  - Otherwise go to FETCH.
- FETCH:
  - fetch_start=1 and fetch_pc=pc, held until fetch_done is sampled.
  - On fetch_done: instr<=fetch_instr; go to EXEC, or to DONE/ST_ABORT if abort or abort_pend.
- EXEC:
  - exec_start=1, exec_pc=pc, exec_instr=instr, held until exec_done.
  - On exec_done: pc<=exec_next_pc; final_pc<=exec_next_pc; iter_count++ (saturating).
  - Exit priority:
    1. exec_halt → DONE, ST_HALT
    2. abort or abort_pend → DONE, ST_ABORT
    3. exec_next_pc[1:0]!=0 → DONE, ST_MISALIGN
    4. lim!=0 and new count==lim, or count saturates at all-ones → DONE, ST_LIMIT
    5. otherwise → FETCH
- Abort during FETCH/EXEC never cancels an in-flight sub-block op. It sets abort_pend, which is honoured at the next fetch_done or exec_done.
- DONE: ap_done=ap_ready=1 for exactly one cycle, then IDLE. iter_count, final_pc and status hold until the next accepted ap_start.
- ap_start in FETCH/EXEC/DONE is ignored. If ap_start is still high in IDLE after DONE, the next run starts.
- fetch_done outside FETCH and exec_done outside EXEC are ignored.
- Start and done may coincide in the same cycle. Minimum iteration = 2 cycles.
- Latency:
  - ap_start accepted in cycle 0 → fetch_start=1 in cycle 1.
  - Last exec_done in cycle n → ap_done in cycle n+1.
- Reset mid-run: immediate return to IDLE; outputs take reset values; sub-block start lines drop asynchronously.

Decomposition:
- Package fetch_seq_pkg:
  - state enum seq_state_t
  - status encoding: ST_NONE=0, ST_HALT=1, ST_LIMIT=2, ST_ABORT=3, ST_MISALIGN=4
  - default width constants
- Sub-module iter_limit_counter (saturating counter plus limit compare, outputs hit flag) is natural. The rest stays flat.

Test Plan:
- start_pc=0x100, max_iter=0, fetch/exec done 1 cycle after start, exec_next_pc=pc+4, exec_halt on 3rd exec_done → ap_done 1 cycle later; iter_count=3, final_pc=0x10C, status=HALT; fetch_pc sequence 0x100, 0x104, 0x108.
- max_iter=5, no halt → exactly 5 exec_start rising phases, iter_count=5, status=LIMIT, ap_ready pulse width 1.
- abort pulsed mid-EXEC of iteration 2 with exec_done 4 cycles later → exec_start held until exec_done; no further fetch_start; iter_count=2, status=ABORT.
- start_pc=0x102 → ap_done 1 cycle after accept; no fetch_start; iter_count=0, status=MISALIGN. Also exec_next_pc=0x206 on iteration 1 → status=MISALIGN, final_pc=0x206.
- ap_rst_n low while in EXEC → same-cycle exec_start=0, ap_idle=1. After release, a new ap_start runs from the freshly latched start_pc with iter_count restarting at 0.
- Spurious exec_done in FETCH and ap_start toggled during run → no state change, no extra iteration counted.

Source files
------------

// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the fetch/execute sequencer.
package fetch_seq_pkg;

    localparam int unsigned DEF_PC_W    = 32;
    localparam int unsigned DEF_INSTR_W = 32;
    localparam int unsigned DEF_CNT_W   = 32;
    localparam int unsigned STATUS_W    = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_DONE  = 2'd3
    } seq_state_t;

    localparam logic [STATUS_W-1:0] ST_NONE     = 3'd0;
    localparam logic [STATUS_W-1:0] ST_HALT     = 3'd1;
    localparam logic [STATUS_W-1:0] ST_LIMIT    = 3'd2;
    localparam logic [STATUS_W-1:0] ST_ABORT    = 3'd3;
    localparam logic [STATUS_W-1:0] ST_MISALIGN = 3'd4;

    // Word alignment test on the two byte-offset bits of a PC.
    function automatic logic pc_misaligned(input logic [1:0] i_lsb);
        return i_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_exec_sequencer_iter_limit_counter.sv
// Saturating iteration counter with a look-ahead limit/saturation hit flag.
module iter_limit_counter
    import fetch_seq_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_inc,
    input  logic [CNT_W-1:0] i_lim,
    output logic [CNT_W-1:0] o_count,
    output logic             o_hit_c
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_inc;

    assign w_count_inc = (r_count == '1) ? r_count : r_count + CNT_W'(1);
    // Hit reflects the count the next increment would produce; lim of zero means unlimited.
    assign o_hit_c     = ((i_lim != '0) && (w_count_inc == i_lim)) || (w_count_inc == '1);
    assign o_count     = r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= w_count_inc;
        end
    end

endmodule

// File: rtl/fetch_exec_sequencer.sv
// Host-controlled sequencer looping fetch -> execute with PC, iteration and exit-cause tracking.
module fetch_exec_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int unsigned PC_W    = DEF_PC_W,
    parameter int unsigned INSTR_W = DEF_INSTR_W,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic               ap_start,
    output logic               ap_done,
    output logic               ap_idle,
    output logic               ap_ready,
    input  logic [PC_W-1:0]    start_pc,
    input  logic [CNT_W-1:0]   max_iter,
    input  logic               abort,
    output logic               fetch_start,
    output logic [PC_W-1:0]    fetch_pc,
    input  logic               fetch_done,
    input  logic [INSTR_W-1:0] fetch_instr,
    output logic               exec_start,
    output logic [PC_W-1:0]    exec_pc,
    output logic [INSTR_W-1:0] exec_instr,
    input  logic               exec_done,
    input  logic [PC_W-1:0]    exec_next_pc,
    input  logic               exec_halt,
    output logic [CNT_W-1:0]   iter_count,
    output logic [PC_W-1:0]    final_pc,
    output logic [2:0]         status
);

    seq_state_t          r_state;
    seq_state_t          w_state_nxt;
    logic [STATUS_W-1:0] r_status;
    logic [STATUS_W-1:0] w_status_nxt;
    logic [PC_W-1:0]     r_pc;
    logic [PC_W-1:0]     r_final_pc;
    logic [INSTR_W-1:0]  r_instr;
    logic [CNT_W-1:0]    r_lim;
    logic                r_abort_pend;
    logic                r_ap_idle;
    logic                r_ap_done;
    logic                r_fetch_start;
    logic                r_exec_start;
    logic                w_accept;
    logic                w_fetch_fire;
    logic                w_exec_fire;
    logic                w_lim_hit;
    logic                w_abort_any;

    assign w_abort_any = abort || r_abort_pend;

    iter_limit_counter #(.CNT_W(CNT_W)) u_iter_cnt (
        .i_clk   (ap_clk),
        .i_rst_n (ap_rst_n),
        .i_clear (w_accept),
        .i_inc   (w_exec_fire),
        .i_lim   (r_lim),
        .o_count (iter_count),
        .o_hit_c (w_lim_hit)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, exit cause and handshake qualifiers.
    always_comb begin
        w_state_nxt  = r_state;
        w_status_nxt = r_status;
        w_accept     = 1'b0;
        w_fetch_fire = 1'b0;
        w_exec_fire  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ap_start) begin
                    w_accept = 1'b1;
                    if (pc_misaligned(start_pc[1:0])) begin
                        w_state_nxt  = S_DONE;
                        w_status_nxt = ST_MISALIGN;
                    end else begin
                        w_state_nxt  = S_FETCH;
                        w_status_nxt = ST_NONE;
                    end
                end
            end
            S_FETCH: begin
                if (fetch_done) begin
                    w_fetch_fire = 1'b1;
                    if (w_abort_any) begin
                        w_state_nxt  = S_DONE;
                        w_status_nxt = ST_ABORT;
                    end else begin
                        w_state_nxt = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    w_exec_fire = 1'b1;
                    w_state_nxt = S_DONE;
                    if (exec_halt) begin
                        w_status_nxt = ST_HALT;
                    end else if (w_abort_any) begin
                        w_status_nxt = ST_ABORT;
                    end else if (pc_misaligned(exec_next_pc[1:0])) begin
                        w_status_nxt = ST_MISALIGN;
                    end else if (w_lim_hit) begin
                        w_status_nxt = ST_LIMIT;
                    end else begin
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath and registered handshake outputs decoded from the next state.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_status      <= ST_NONE;
            r_pc          <= '0;
            r_final_pc    <= '0;
            r_instr       <= '0;
            r_lim         <= '0;
            r_abort_pend  <= 1'b0;
            r_ap_idle     <= 1'b1;
            r_ap_done     <= 1'b0;
            r_fetch_start <= 1'b0;
            r_exec_start  <= 1'b0;
        end else begin
            r_status      <= w_status_nxt;
            r_ap_idle     <= (w_state_nxt == S_IDLE);
            r_ap_done     <= (w_state_nxt == S_DONE);
            r_fetch_start <= (w_state_nxt == S_FETCH);
            r_exec_start  <= (w_state_nxt == S_EXEC);
            if (w_accept) begin
                r_pc         <= start_pc;
                r_lim        <= max_iter;
                r_abort_pend <= 1'b0;
            end else if (abort && ((r_state == S_FETCH) || (r_state == S_EXEC))) begin
                r_abort_pend <= 1'b1;
            end
            if (w_fetch_fire) begin
                r_instr <= fetch_instr;
            end
            if (w_exec_fire) begin
                r_pc       <= exec_next_pc;
                r_final_pc <= exec_next_pc;
            end
        end
    end

    assign ap_done     = r_ap_done;
    assign ap_ready    = r_ap_done;
    assign ap_idle     = r_ap_idle;
    assign fetch_start = r_fetch_start;
    assign fetch_pc    = r_pc;
    assign exec_start  = r_exec_start;
    assign exec_pc     = r_pc;
    assign exec_instr  = r_instr;
    assign final_pc    = r_final_pc;
    assign status      = r_status;

endmodule

// File: tb/tb_fetch_exec_sequencer.sv
// Directed bench for fetch_exec_sequencer with a latency-configurable fetch/execute responder.
module tb_fetch_exec_sequencer;

    logic        ap_clk;
    logic        ap_rst_n;
    logic        ap_start;
    logic        ap_done;
    logic        ap_idle;
    logic        ap_ready;
    logic [31:0] start_pc;
    logic [31:0] max_iter;
    logic        abort;
    logic        fetch_start;
    logic [31:0] fetch_pc;
    logic        fetch_done;
    logic [31:0] fetch_instr;
    logic        exec_start;
    logic [31:0] exec_pc;
    logic [31:0] exec_instr;
    logic        exec_done;
    logic [31:0] exec_next_pc;
    logic        exec_halt;
    logic [31:0] iter_count;
    logic [31:0] final_pc;
    logic [2:0]  status;

    fetch_exec_sequencer dut (
        .ap_clk       (ap_clk),
        .ap_rst_n     (ap_rst_n),
        .ap_start     (ap_start),
        .ap_done      (ap_done),
        .ap_idle      (ap_idle),
        .ap_ready     (ap_ready),
        .start_pc     (start_pc),
        .max_iter     (max_iter),
        .abort        (abort),
        .fetch_start  (fetch_start),
        .fetch_pc     (fetch_pc),
        .fetch_done   (fetch_done),
        .fetch_instr  (fetch_instr),
        .exec_start   (exec_start),
        .exec_pc      (exec_pc),
        .exec_instr   (exec_instr),
        .exec_done    (exec_done),
        .exec_next_pc (exec_next_pc),
        .exec_halt    (exec_halt),
        .iter_count   (iter_count),
        .final_pc     (final_pc),
        .status       (status)
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Responder configuration (written only by the main thread, between runs).
    int fl = 1, el = 1, halt_at = 0, mis_at = 0;
    bit spur_en = 1'b0;

    // Responder-owned observations.
    int f_cnt = 0, e_cnt = 0, ex_n = 0, instr_bad = 0, xd_cyc = 0;
    logic [31:0] fetch_log[$];

    // Monitor-owned observations.
    int cyc = 0, n_done = 0, done_cyc = 0, n_fetch_rise = 0, n_exec_rise = 0, n_wide = 0;
    logic prev_fs = 1'b0, prev_es = 1'b0, prev_rdy = 1'b0;

    always @(posedge ap_clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(negedge ap_clk);
            if (fetch_start && !prev_fs) n_fetch_rise++;
            if (exec_start && !prev_es) n_exec_rise++;
            if (ap_done) begin n_done++; done_cyc = cyc; end
            if (ap_ready && prev_rdy) n_wide++;
            prev_fs  = fetch_start;
            prev_es  = exec_start;
            prev_rdy = ap_ready;
        end
    end

    // Fetch/execute unit model: done after fl/el cycles of a held start.
    initial begin
        fetch_done = 1'b0; fetch_instr = '0; exec_done = 1'b0; exec_halt = 1'b0; exec_next_pc = '0;
        forever begin
            @(posedge ap_clk); #1;
            fetch_done = 1'b0; fetch_instr = '0;
            exec_done = 1'b0; exec_halt = 1'b0; exec_next_pc = '0;
            if (ap_idle) ex_n = 0;
            if (fetch_start) begin
                if (spur_en && f_cnt == 1) begin
                    exec_done = 1'b1; exec_halt = 1'b1; exec_next_pc = 32'h777;
                end
                if (f_cnt >= fl) begin
                    fetch_done  = 1'b1;
                    fetch_instr = {16'hA5A5, fetch_pc[15:0]};
                    fetch_log.push_back(fetch_pc);
                    f_cnt = 0;
                end else f_cnt++;
            end else f_cnt = 0;
            if (exec_start) begin
                if (e_cnt >= el) begin
                    ex_n++;
                    exec_done    = 1'b1;
                    exec_halt    = (ex_n == halt_at);
                    exec_next_pc = exec_pc + ((ex_n == mis_at) ? 32'd6 : 32'd4);
                    if (exec_instr !== {16'hA5A5, exec_pc[15:0]}) instr_bad++;
                    xd_cyc = cyc;
                    e_cnt  = 0;
                end else e_cnt++;
            end else e_cnt = 0;
        end
    end

    int acc_cyc, done_base, fetch_base, exec_base, wide_base, log_base;

    task automatic start_run(input logic [31:0] pc, input logic [31:0] lim, input logic exp_fs);
        @(posedge ap_clk); #1;
        start_pc   = pc;
        max_iter   = lim;
        ap_start   = 1'b1;
        acc_cyc    = cyc;
        done_base  = n_done;
        fetch_base = n_fetch_rise;
        exec_base  = n_exec_rise;
        wide_base  = n_wide;
        log_base   = fetch_log.size();
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
        @(negedge ap_clk); #1;
        check_eq("fetch_start_latency", fetch_start, exp_fs);
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (n_done == done_base && k < 300) begin
            @(negedge ap_clk); #1;
            k++;
        end
        check_eq(tag, n_done - done_base, 1);
    endtask

    task automatic wait_exec_rise(input int nth);
        int k;
        k = 0;
        while ((n_exec_rise - exec_base) < nth && k < 300) begin
            @(negedge ap_clk); #1;
            k++;
        end
        check_eq("exec_rise_reached", n_exec_rise - exec_base, nth);
    endtask

    initial begin
        ap_rst_n = 1'b0; ap_start = 1'b0; start_pc = '0; max_iter = '0; abort = 1'b0;
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk); #1;
        check_eq("rst_idle", ap_idle, 1);
        check_eq("rst_done", ap_done, 0);
        check_eq("rst_fetch_start", fetch_start, 0);
        check_eq("rst_exec_start", exec_start, 0);
        check_eq("rst_iter", iter_count, 0);
        check_eq("rst_final_pc", final_pc, 0);
        check_eq("rst_status", status, 0);
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;

        // Halt on third iteration.
        fl = 1; el = 1; halt_at = 3;
        start_run(32'h100, 0, 1'b1);
        wait_done("t1_done");
        check_eq("t1_iter", iter_count, 3);
        check_eq("t1_final_pc", final_pc, 32'h10C);
        check_eq("t1_status", status, 1);
        check_eq("t1_done_latency", done_cyc - xd_cyc, 1);
        check_eq("t1_fpc0", fetch_log[log_base], 32'h100);
        check_eq("t1_fpc1", fetch_log[log_base+1], 32'h104);
        check_eq("t1_fpc2", fetch_log[log_base+2], 32'h108);
        @(negedge ap_clk); #1;
        check_eq("t1_idle_after", ap_idle, 1);
        halt_at = 0;

        // Iteration limit with zero-latency sub-blocks.
        fl = 0; el = 0;
        start_run(32'h40, 5, 1'b1);
        wait_done("t2_done");
        check_eq("t2_ready", ap_ready, 1);
        check_eq("t2_iter", iter_count, 5);
        check_eq("t2_status", status, 2);
        check_eq("t2_final_pc", final_pc, 32'h54);
        @(negedge ap_clk); #1;
        check_eq("t2_exec_rises", n_exec_rise - exec_base, 5);
        check_eq("t2_ready_width", n_wide - wide_base, 0);

        // Abort pulsed mid-execute of iteration 2.
        fl = 1; el = 4;
        start_run(32'h300, 0, 1'b1);
        wait_exec_rise(2);
        @(posedge ap_clk); #1; abort = 1'b1;
        @(posedge ap_clk); #1; abort = 1'b0;
        @(negedge ap_clk); #1;
        check_eq("t3_exec_held", exec_start, 1);
        wait_done("t3_done");
        check_eq("t3_iter", iter_count, 2);
        check_eq("t3_status", status, 3);
        check_eq("t3_final_pc", final_pc, 32'h308);
        check_eq("t3_fetch_rises", n_fetch_rise - fetch_base, 2);

        // Misaligned start PC, then misaligned next PC.
        fl = 1; el = 1;
        start_run(32'h102, 7, 1'b0);
        wait_done("t4a_done");
        check_eq("t4a_latency", done_cyc - acc_cyc, 1);
        check_eq("t4a_iter", iter_count, 0);
        check_eq("t4a_status", status, 4);
        check_eq("t4a_fetch_rises", n_fetch_rise - fetch_base, 0);
        mis_at = 1;
        start_run(32'h200, 0, 1'b1);
        wait_done("t4b_done");
        check_eq("t4b_status", status, 4);
        check_eq("t4b_final_pc", final_pc, 32'h206);
        check_eq("t4b_iter", iter_count, 1);
        mis_at = 0;

        // Reset while executing, then a fresh run.
        el = 4;
        start_run(32'h400, 0, 1'b1);
        wait_exec_rise(1);
        @(posedge ap_clk); #3;
        ap_rst_n = 1'b0;
        #1;
        check_eq("t5_exec_drop", exec_start, 0);
        check_eq("t5_idle", ap_idle, 1);
        check_eq("t5_status", status, 0);
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        el = 1;
        start_run(32'h500, 2, 1'b1);
        wait_done("t5_done");
        check_eq("t5_first_fpc", fetch_log[log_base], 32'h500);
        check_eq("t5_iter", iter_count, 2);
        check_eq("t5_final_pc", final_pc, 32'h508);

        // Spurious exec_done during fetch and ap_start toggled mid-run.
        fl = 3; el = 1; spur_en = 1'b1;
        start_run(32'h600, 3, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(posedge ap_clk); #1;
            ap_start = ~ap_start;
        end
        ap_start = 1'b0;
        wait_done("t6_done");
        check_eq("t6_iter", iter_count, 3);
        check_eq("t6_status", status, 2);
        check_eq("t6_final_pc", final_pc, 32'h60C);
        check_eq("t6_fetch_rises", n_fetch_rise - fetch_base, 3);
        spur_en = 1'b0;
        repeat (3) @(negedge ap_clk);
        #1;
        check_eq("t6_no_restart", n_done - done_base, 1);
        check_eq("t6_idle", ap_idle, 1);
        check_eq("instr_latch_errors", instr_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
